mux_kn_to_n_arb: RTL and testbench

MUX_KN_TO_N_ARB -- requirements
Module: mux_kn_to_n_arb

---
 rtl/mux_kn_to_n_arb.sv | 97 +++++++++
 tb/tb_mux_kn_to_n_arb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux_kn_to_n_arb.sv
// K-to-1 channel mux feeding a single registered output slot.
// Channel choice is either direct (S) or round-robin after the last grant.
module mux_kn_to_n_arb #(
  parameter int N  = 32,
  parameter int K  = 8,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [K*N-1:0]       I,
  input  logic [K-1:0]         in_valid,
  output logic [K-1:0]         in_ready,
  input  logic [$clog2(K)-1:0] S,
  input  logic                 mode,
  input  logic                 enable,
  output logic [N-1:0]         O,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(K)-1:0] O_src,
  output logic [CW-1:0]        xfer_cnt
);
  localparam int SW = $clog2(K);

  logic [K-1:0][N-1:0] ch_data;
  assign ch_data = I;

  logic [N-1:0]  o_q, o_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [SW-1:0] rr_idx, rr_c, cand;
  logic          rr_hit, cand_hit, slot_free, load;

  // Walk the search order backwards so the nearest valid channel after ptr
  // is the last one written. ptr+K wraps to ptr itself since K is 2^SW.
  always_comb begin
    rr_idx = '0;
    rr_c   = '0;
    rr_hit = 1'b0;
    for (int k = K; k >= 1; k--) begin
      rr_idx = ptr_q + SW'(k);
      if (in_valid[rr_idx]) begin
        rr_hit = 1'b1;
        rr_c   = rr_idx;
      end
    end
  end

  always_comb begin
    cand      = mode ? rr_c : S;
    cand_hit  = mode ? rr_hit : in_valid[S];
    slot_free = !vld_q || out_ready;
    load      = rst && enable && slot_free && cand_hit;

    in_ready = '0;
    o_d      = o_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;

    if (load) begin
      in_ready[cand] = 1'b1;
      o_d            = ch_data[cand];
      src_d          = cand;
      ptr_d          = cand;
      vld_d          = 1'b1;
      cnt_d          = cnt_q + CW'(1);
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_q   <= '0;
      src_q <= '0;
      ptr_q <= SW'(K - 1);
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      o_q   <= o_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign O         = o_q;
  assign O_src     = src_q;
  assign out_valid = vld_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_kn_to_n_arb.sv
// Directed vector table followed by randomized traffic checked against a
// queue-free behavioural model of the arbiter and output slot.
module tb_mux_kn_to_n_arb;
  localparam int N  = 32;
  localparam int K  = 8;
  localparam int CW = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [K*N-1:0]  I;
  logic [K-1:0]    in_valid, in_ready;
  logic [SW-1:0]   S, O_src;
  logic            mode, enable, out_valid, out_ready;
  logic [N-1:0]    O;
  logic [CW-1:0]   xfer_cnt;

  always #5 clk = ~clk;

  mux_kn_to_n_arb #(.N(N), .K(K), .CW(CW)) dut (
    .clk(clk), .rst(rst), .I(I), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .mode(mode), .enable(enable), .O(O), .out_valid(out_valid),
    .out_ready(out_ready), .O_src(O_src), .xfer_cnt(xfer_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pat(input int i);
    if (i == 5) return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 + i * 32'h111;
  endfunction

  typedef struct {
    logic          r, m, en, ordy;
    logic [SW-1:0] s;
    logic [K-1:0]  iv, rdy;
    logic          vld;
    logic [SW-1:0] src;
    logic [N-1:0]  o;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t          tbl[$];
  logic [CW-1:0] t_cnt;
  logic [N-1:0]  t_o;
  logic [SW-1:0] t_src;

  // g is the channel expected to be granted this cycle, -1 for none.
  task automatic add(input logic r, input logic m, input int s, input logic en,
                     input logic [K-1:0] iv, input logic ordy, input int g, input logic vld);
    vec_t v;
    v.r = r; v.m = m; v.s = SW'(s); v.en = en; v.iv = iv; v.ordy = ordy;
    v.rdy = '0;
    if (!r) begin
      t_cnt = '0; t_o = '0; t_src = '0;
    end else if (g >= 0) begin
      v.rdy[g] = 1'b1;
      t_cnt = t_cnt + 1'b1; t_o = pat(g); t_src = SW'(g);
    end
    v.vld = vld; v.src = t_src; v.o = t_o; v.cnt = t_cnt;
    tbl.push_back(v);
  endtask

  // Behavioural reference state
  logic [N-1:0]  m_o;
  logic [SW-1:0] m_src;
  logic          m_vld;
  int            m_cnt, m_ptr;

  function automatic int pick(input logic md, input int s, input logic [K-1:0] iv, input int ptr);
    if (!md) return iv[s] ? s : -1;
    for (int k = 1; k <= K; k++)
      if (iv[(ptr + k) % K]) return (ptr + k) % K;
    return -1;
  endfunction

  initial begin
    rst = 1'b0; mode = 1'b0; S = '0; enable = 1'b0; in_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < K; i++) I[i*N +: N] = pat(i);

    t_cnt = '0; t_o = '0; t_src = '0;
    add(0, 0, 0, 1, 8'hFF, 1, -1, 0);
    add(1, 0, 5, 1, 8'h20, 1,  5, 1);              // direct S=5
    add(1, 0, 5, 0, 8'hFF, 1, -1, 0);              // enable=0 still drains
    add(0, 1, 0, 1, 8'hFF, 1, -1, 0);
    for (int g = 0; g < 10; g++) add(1, 1, 0, 1, 8'hFF, 1, g % K, 1);
    add(0, 1, 0, 1, 8'hFF, 1, -1, 0);              // reset discards held word
    add(1, 1, 0, 1, 8'hFF, 1,  0, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 8'hFF, 0, -1, 1);  // stalled
    add(1, 1, 0, 1, 8'hFF, 1,  1, 1);              // consume+load same cycle
    add(1, 0, 4, 1, 8'h10, 1,  4, 1);              // ptr=4 via direct grant
    add(1, 1, 0, 1, 8'h90, 1,  7, 1);
    add(1, 1, 0, 1, 8'h90, 1,  4, 1);
    add(1, 1, 0, 1, 8'h90, 1,  7, 1);
    add(1, 0, 2, 1, 8'hFB, 1, -1, 0);              // S invalid, others valid
    add(1, 0, 3, 1, 8'h08, 1,  3, 1);
    add(1, 1, 0, 1, 8'hFF, 1,  4, 1);              // RR resumes after direct grant
    add(1, 1, 0, 0, 8'hFF, 0, -1, 1);

    foreach (tbl[n]) begin
      rst = tbl[n].r; mode = tbl[n].m; S = tbl[n].s; enable = tbl[n].en;
      in_valid = tbl[n].iv; out_ready = tbl[n].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", n), 64'(in_ready), 64'(tbl[n].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", n), 64'(out_valid), 64'(tbl[n].vld));
      chk($sformatf("vec%0d O_src", n), 64'(O_src), 64'(tbl[n].src));
      chk($sformatf("vec%0d O", n), 64'(O), 64'(tbl[n].o));
      chk($sformatf("vec%0d xfer_cnt", n), 64'(xfer_cnt), 64'(tbl[n].cnt));
    end

    m_o = '0; m_src = '0; m_vld = 1'b0; m_cnt = 0; m_ptr = K - 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int c;
      logic ld;
      logic [K-1:0] exp_rdy;
      rst       = (cyc == 0) ? 1'b0 : ($urandom_range(0, 60) != 0);
      mode      = ($urandom_range(0, 3) != 0);
      S         = SW'($urandom_range(0, K - 1));
      enable    = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 1) != 0) ? K'($urandom & $urandom) : K'($urandom);
      for (int i = 0; i < K; i++) I[i*N +: N] = $urandom;
      c  = pick(mode, int'(S), in_valid, m_ptr);
      ld = rst && enable && (!m_vld || out_ready) && (c >= 0);
      exp_rdy = '0;
      if (ld) exp_rdy[c] = 1'b1;
      #1;
      chk($sformatf("rnd%0d in_ready", cyc), 64'(in_ready), 64'(exp_rdy));
      if (!rst) begin
        m_o = '0; m_src = '0; m_vld = 1'b0; m_cnt = 0; m_ptr = K - 1;
      end else if (ld) begin
        m_o = I[c*N +: N]; m_src = SW'(c); m_vld = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CW); m_ptr = c;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d out_valid", cyc), 64'(out_valid), 64'(m_vld));
      chk($sformatf("rnd%0d O_src", cyc), 64'(O_src), 64'(m_src));
      chk($sformatf("rnd%0d O", cyc), 64'(O), 64'(m_o));
      chk($sformatf("rnd%0d xfer_cnt", cyc), 64'(xfer_cnt), 64'(m_cnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
